btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the pipelined core.
- Sits beside fetch: looks up the fetch PC and returns, one cycle later, a registered hit/taken/target prediction.
- Trained from the execute stage with resolved branch outcomes.
- Adds over the previous fixed 4-entry BTB: sets × ways indexing, per-entry saturating direction counters, round-robin replacement per set, and a global invalidate.

Parameters:
- PC_W, 16, PC and target width in bits.
- IDX_W, 2, set index bits; SETS = 2**IDX_W.
- WAYS, 4, ways per set (1..8).
- CTR_W, 2, direction counter width; predict taken when counter MSB = 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- lk_valid  input  1  fetch lookup request this cycle.
- lk_pc  input  PC_W  fetch PC.
- pred_valid  output  1  registered: a lookup was made last cycle.
- pred_hit  output  1  registered: last lookup hit a valid entry.
- pred_taken  output  1  registered: hit AND counter MSB = 1.
- pred_target  output  PC_W  registered: stored target on hit, else 0.
- upd_valid  input  1  execute-stage training request.
- upd_pc  input  PC_W  PC of the resolved branch.
- upd_target  input  PC_W  resolved taken-target.
- upd_taken  input  1  resolved direction.
- inv_all  input  1  invalidate all entries (context switch or self-modifying code).

Behaviour:
- Address split: index = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
- Entry contents: valid, tag, target, ctr. Each set also holds a round-robin victim pointer (clog2(WAYS) bits).
- Reset (synchronous, rst high at posedge):
  - All valid bits, counters and victim pointers cleared.
  - pred_valid, pred_hit, pred_taken = 0; pred_target = 0.
  - rst has priority over inv_all, upd_valid and lk_valid.
- Lookup, 1-cycle latency: lk_valid at edge N gives pred_* valid after edge N+1.
  - If lk_valid is low, pred_valid = 0 and the other pred_* outputs are 0.
  - Hit = any way in the set with valid and matching tag.
  - At most one way can match (guaranteed by the update rule). A multi-match is an assertion failure.
- Update, applied at posedge when upd_valid:
  - Hit in way w: ctr saturating +1 if upd_taken, -1 otherwise (no wrap past 0 or 2**CTR_W-1). If upd_taken, target := upd_target.
  - Miss and upd_taken: allocate. Choose the lowest-index invalid way; if none is invalid, the way at the victim pointer. Write valid = 1, tag, target; ctr := 2**(CTR_W-1) (weakly taken). Victim pointer advances by 1 (mod WAYS) only when a valid entry was evicted.
  - Miss and not taken: no state change. Not-taken branches are never allocated.
- Simultaneous lookup and update to the same entry in one cycle: the lookup returns the pre-update contents (read-before-write).
- inv_all at posedge: clears all valid bits and victim pointers.
  - Counters and targets are don't-care afterwards.
  - An update in the same cycle is discarded.
  - A lookup in the same cycle returns pre-invalidate contents.
- Storage uses flops, not RAM macros. Total entries = SETS × WAYS.

Test Plan:
- Reset then lookup 0x0040 → one cycle later pred_valid = 1, pred_hit = 0, pred_taken = 0, pred_target = 0x0000.
- Train 0x0040 → 0x0100 taken, then look it up → hit = 1, taken = 1 (ctr = 2), target = 0x0100. Two not-taken updates → ctr = 0, lookup gives hit = 1, taken = 0. A third not-taken update keeps ctr at 0 (saturation).
- Fill set 0 (IDX_W = 2) with taken branches at 0x0000, 0x0004, 0x0008, 0x000C, then train 0x0010 taken → entry 0x0000 is evicted (victim pointer 0 → 1). Next allocation to set 0 evicts 0x0004.
- Same-cycle lookup and update of new PC 0x0020 (taken) → lookup misses that cycle, the following lookup hits.
- inv_all after the table is populated → every prior PC misses. inv_all together with upd_valid → the update is dropped.
- rst asserted while lk_valid and upd_valid are high → next cycle pred_valid = 0 and the trained PC misses.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered lookup beside fetch, trained from execute.
// Flop storage, saturating direction counters, per-set round-robin victim pointer, global invalidate.
module btb_assoc #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 2,
    parameter int WAYS  = 4,
    parameter int CTR_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lk_valid,
    input  logic [PC_W-1:0] lk_pc,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            inv_all
);
    localparam int SETS  = 2 ** IDX_W;
    localparam int TAG_W = PC_W - IDX_W;
    localparam int WI_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [WI_W-1:0]  LAST_WAY = WI_W'(WAYS - 1);

    logic [WAYS-1:0]  valid_q  [SETS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [PC_W-1:0]  target_q [SETS][WAYS];
    logic [CTR_W-1:0] ctr_q    [SETS][WAYS];
    logic [WI_W-1:0]  vptr_q   [SETS];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    assign lk_idx  = lk_pc[IDX_W-1:0];
    assign lk_tag  = lk_pc[PC_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[PC_W-1:IDX_W];

    logic [WAYS-1:0] lk_match;
    logic [PC_W-1:0] lk_target;
    logic            lk_msb;
    logic            lk_hit;

    always_comb begin
        lk_match  = '0;
        lk_target = '0;
        lk_msb    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
            if (lk_match[w]) begin
                lk_target = lk_target | target_q[lk_idx][w];
                lk_msb    = lk_msb | ctr_q[lk_idx][w][CTR_W-1];
            end
        end
    end
    assign lk_hit = |lk_match;

    logic            upd_hit, has_free;
    logic [WI_W-1:0] hit_way, free_way, alloc_way;

    // Descending scan for free ways so the lowest-index invalid way wins.
    always_comb begin
        upd_hit  = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_hit = 1'b1;
                hit_way = WI_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                has_free = 1'b1;
                free_way = WI_W'(w);
            end
        end
    end
    assign alloc_way = has_free ? free_way : vptr_q[upd_idx];

    // All reads above see pre-edge state, giving read-before-write for lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= '0;
            end
        end else begin
            pred_valid  <= lk_valid;
            pred_hit    <= lk_valid && lk_hit;
            pred_taken  <= lk_valid && lk_hit && lk_msb;
            pred_target <= lk_valid ? lk_target : '0;
            if (inv_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    vptr_q[s]  <= '0;
                end
            end else if (upd_valid) begin
                if (upd_hit) begin
                    if (upd_taken) begin
                        if (ctr_q[upd_idx][hit_way] != CTR_MAX)
                            ctr_q[upd_idx][hit_way] <= ctr_q[upd_idx][hit_way] + 1'b1;
                        target_q[upd_idx][hit_way] <= upd_target;
                    end else if (ctr_q[upd_idx][hit_way] != '0) begin
                        ctr_q[upd_idx][hit_way] <= ctr_q[upd_idx][hit_way] - 1'b1;
                    end
                end else if (upd_taken) begin
                    valid_q[upd_idx][alloc_way]  <= 1'b1;
                    tag_q[upd_idx][alloc_way]    <= upd_tag;
                    target_q[upd_idx][alloc_way] <= upd_target;
                    ctr_q[upd_idx][alloc_way]    <= CTR_INIT;
                    if (!has_free)
                        vptr_q[upd_idx] <= (vptr_q[upd_idx] == LAST_WAY) ? '0 : vptr_q[upd_idx] + 1'b1;
                end
            end
        end
    end

    a_single_match: assert property (@(posedge clk) disable iff (rst) lk_valid |-> $onehot0(lk_match));

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed vector table with hand-derived expectations,
// then randomized traffic checked against a behavioural BTB model.
module tb_btb_assoc;
    localparam int SETS = 4;
    localparam int WAYS = 4;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst, lk_valid, upd_valid, upd_taken, inv_all;
    logic [15:0] lk_pc, upd_pc, upd_target;
    logic        pred_valid, pred_hit, pred_taken;
    logic [15:0] pred_target;

    int checks   = 0;
    int failures = 0;

    btb_assoc dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken),
        .inv_all(inv_all)
    );

    always #5 clk = ~clk;

    // Behavioural model: per set, a list of entries indexed by way.
    bit m_v   [SETS][WAYS];
    int m_tag [SETS][WAYS];
    int m_tgt [SETS][WAYS];
    int m_ctr [SETS][WAYS];
    int m_vp  [SETS];

    function automatic void m_clear(input bit full);
        for (int s = 0; s < SETS; s++) begin
            m_vp[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 0;
                if (full) m_ctr[s][w] = 0;
            end
        end
    endfunction

    function automatic logic [18:0] m_lookup(input bit lv, input int pc);
        int s, t;
        s = pc % SETS;
        t = pc / SETS;
        if (!lv) return 19'h0;
        for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] && m_tag[s][w] == t)
                return {1'b1, 1'b1, (m_ctr[s][w] >= 2) ? 1'b1 : 1'b0, 16'(m_tgt[s][w])};
        return {3'b100, 16'h0};
    endfunction

    function automatic void m_update(input int pc, input int tgt, input bit tk);
        int s, t, way;
        s = pc % SETS;
        t = pc / SETS;
        for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] && m_tag[s][w] == t) begin
                if (tk) begin
                    m_ctr[s][w] = (m_ctr[s][w] < CMAX) ? m_ctr[s][w] + 1 : CMAX;
                    m_tgt[s][w] = tgt;
                end else begin
                    m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
                end
                return;
            end
        if (!tk) return;
        way = -1;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!m_v[s][w]) way = w;
        if (way < 0) begin
            way = m_vp[s];
            m_vp[s] = (m_vp[s] + 1) % WAYS;
        end
        m_v[s][way]   = 1;
        m_tag[s][way] = t;
        m_tgt[s][way] = tgt;
        m_ctr[s][way] = 2;
    endfunction

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] act;
        act = {pred_valid, pred_hit, pred_taken, pred_target};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got v/h/t/tgt=%b/%b/%b/%h expected %b/%b/%b/%h",
                     name, act[18], act[17], act[16], act[15:0],
                     exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Drive one cycle; returns the model's expected outputs after the edge.
    task automatic cycle(input bit r, input bit lv, input int lpc, input bit uv,
                         input int upc, input int utgt, input bit utk, input bit inv,
                         output logic [18:0] exp);
        rst = r; lk_valid = lv; lk_pc = 16'(lpc);
        upd_valid = uv; upd_pc = 16'(upc); upd_target = 16'(utgt); upd_taken = utk;
        inv_all = inv;
        exp = r ? 19'h0 : m_lookup(lv, lpc);
        if (r) m_clear(1);
        else if (inv) m_clear(0);
        else if (uv) m_update(lpc == lpc ? upc : upc, utgt, utk);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit r; bit lv; int lpc; bit uv; int upc; int utgt; bit utk; bit inv;
        logic [18:0] exp;
        string name;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit r, input bit lv, input int lpc, input bit uv, input int upc,
                       input int utgt, input bit utk, input bit inv, input logic [18:0] exp,
                       input string name);
        vec_t v;
        v.r = r; v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.utgt = utgt;
        v.utk = utk; v.inv = inv; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    localparam logic [2:0] MISS = 3'b100, HIT_T = 3'b111, HIT_N = 3'b110, NONE = 3'b000;

    initial begin
        logic [18:0] e;
        rst = 1'b1; lk_valid = 0; lk_pc = 0; upd_valid = 0; upd_pc = 0;
        upd_target = 0; upd_taken = 0; inv_all = 0;

        //   r lv lpc     uv upc     utgt    tk inv expected
        add(1, 1, 'h40,   1, 'h40,   'h100,  1, 0, {NONE, 16'h0},     "reset_prio");
        add(0, 1, 'h40,   0, 0,      0,      0, 0, {MISS, 16'h0},     "cold_miss");
        add(0, 0, 0,      1, 'h40,   'h100,  1, 0, {NONE, 16'h0},     "no_lookup");
        add(0, 1, 'h40,   0, 0,      0,      0, 0, {HIT_T, 16'h0100}, "trained_hit");
        add(0, 0, 0,      1, 'h40,   0,      0, 0, {NONE, 16'h0},     "nt1");
        add(0, 1, 'h40,   1, 'h40,   0,      0, 0, {HIT_N, 16'h0100}, "ctr1_rbw");
        add(0, 1, 'h40,   1, 'h40,   0,      0, 0, {HIT_N, 16'h0100}, "ctr0_sat_upd");
        add(0, 1, 'h40,   0, 0,      0,      0, 0, {HIT_N, 16'h0100}, "ctr_no_wrap");
        add(0, 1, 'h40,   1, 'h40,   'h200,  1, 0, {HIT_N, 16'h0100}, "tgt_rbw");
        add(0, 1, 'h40,   0, 0,      0,      0, 0, {HIT_N, 16'h0200}, "tgt_updated");
        add(1, 0, 0,      0, 0,      0,      0, 0, {NONE, 16'h0},     "reset2");
        add(0, 0, 0,      1, 'h00,   'h1000, 1, 0, {NONE, 16'h0},     "fill0");
        add(0, 0, 0,      1, 'h04,   'h1004, 1, 0, {NONE, 16'h0},     "fill1");
        add(0, 0, 0,      1, 'h08,   'h1008, 1, 0, {NONE, 16'h0},     "fill2");
        add(0, 0, 0,      1, 'h0C,   'h100C, 1, 0, {NONE, 16'h0},     "fill3");
        add(0, 1, 'h00,   1, 'h10,   'h1010, 1, 0, {HIT_T, 16'h1000}, "pre_evict");
        add(0, 1, 'h00,   0, 0,      0,      0, 0, {MISS, 16'h0},     "evicted_w0");
        add(0, 1, 'h10,   1, 'h14,   'h1014, 1, 0, {HIT_T, 16'h1010}, "new_entry");
        add(0, 1, 'h04,   0, 0,      0,      0, 0, {MISS, 16'h0},     "evicted_w1");
        add(0, 1, 'h08,   0, 0,      0,      0, 0, {HIT_T, 16'h1008}, "kept_w2");
        add(0, 1, 'h20,   1, 'h20,   'h2020, 1, 0, {MISS, 16'h0},     "same_cyc_miss");
        add(0, 1, 'h20,   0, 0,      0,      0, 0, {HIT_T, 16'h2020}, "same_cyc_next");
        add(0, 1, 'h08,   0, 0,      0,      0, 0, {MISS, 16'h0},     "evicted_w2");
        add(0, 1, 'h0C,   0, 0,      0,      0, 1, {HIT_T, 16'h100C}, "inv_rbw");
        add(0, 1, 'h0C,   0, 0,      0,      0, 0, {MISS, 16'h0},     "inv_miss_a");
        add(0, 1, 'h10,   0, 0,      0,      0, 0, {MISS, 16'h0},     "inv_miss_b");
        add(0, 0, 0,      1, 'h31,   'h3031, 1, 1, {NONE, 16'h0},     "inv_with_upd");
        add(0, 1, 'h31,   0, 0,      0,      0, 0, {MISS, 16'h0},     "upd_dropped");
        add(0, 0, 0,      1, 'h31,   'h3031, 1, 0, {NONE, 16'h0},     "retrain");
        add(0, 1, 'h31,   0, 0,      0,      0, 0, {HIT_T, 16'h3031}, "retrain_hit");
        add(1, 1, 'h31,   1, 'h31,   'h3031, 1, 0, {NONE, 16'h0},     "rst_over_all");
        add(0, 1, 'h31,   0, 0,      0,      0, 0, {MISS, 16'h0},     "rst_cleared");

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc,
                  vecs[i].utgt, vecs[i].utk, vecs[i].inv, e);
            check(vecs[i].name, vecs[i].exp);
        end

        // Victim pointer restarts at way 0 after invalidate: fill set 1, then refill.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, e);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 1, 1 + 4 * k, 'h500 + k, 1, 0, e);
        end
        cycle(0, 1, 1, 0, 0, 0, 0, 0, e);
        check("rr_evict_first", {MISS, 16'h0});
        cycle(0, 1, 5, 0, 0, 0, 0, 0, e);
        check("rr_keep_second", {HIT_T, 16'h0501});

        // Randomized traffic against the model.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, e);
        for (int n = 0; n < 3000; n++) begin
            bit r, lv, uv, tk, inv;
            int lpc, upc;
            r   = ($urandom_range(0, 199) == 0);
            inv = ($urandom_range(0, 59) == 0);
            lv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 1) != 0);
            tk  = ($urandom_range(0, 9) < 6);
            lpc = $urandom_range(0, 31);
            upc = $urandom_range(0, 31);
            cycle(r, lv, lpc, uv, upc, $urandom_range(0, 16'hFFFF), tk, inv, e);
            check("random", e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
